// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage (shift-add / restoring divide).
// Divide/remainder (funct3 4-7) is built only when MULDIV_DIV_EN is defined; otherwise it returns 0.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [4:0]      rd_i,
   output logic            busy_o,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_REM    = 3'd6;

   state_t            state, state_nxt;
   logic [5:0]        cnt;
   logic [2:0]        op;
   logic [4:0]        rd_lat;
   logic              neg;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc, acc_nxt, prod;
   logic [XLEN:0]     sum;
   logic [XLEN-1:0]   fin, mag1, mag2, special_res;
   logic              s1, s2, neg_in, special, last;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   qr;
`endif

   assign last = (cnt == 6'(XLEN-1));

   // Effective operand signs by opcode; unsigned forms leave both flags clear.
   always_comb begin
      s1 = 1'b0;
      s2 = 1'b0;
      case (funct3_i)
         F_MULH, F_DIV, F_REM: begin
            s1 = op1_i[XLEN-1];
            s2 = op2_i[XLEN-1];
         end
         F_MULHSU: s1 = op1_i[XLEN-1];
         default: ;
      endcase
   end

   assign mag1   = s1 ? -op1_i : op1_i;
   assign mag2   = s2 ? -op2_i : op2_i;
   assign neg_in = (funct3_i == F_REM) ? s1 : (s1 ^ s2);

`ifdef MULDIV_DIV_EN
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (funct3_i[2]) begin
         if (op2_i == '0) begin
            special     = 1'b1;
            special_res = funct3_i[1] ? op1_i : '1;
         end else if (!funct3_i[0] && op1_i == {1'b1, {(XLEN-1){1'b0}}} && op2_i == '1) begin
            special     = 1'b1;
            special_res = funct3_i[1] ? '0 : op1_i;
         end
      end
   end
`else
   assign special     = funct3_i[2];
   assign special_res = '0;
`endif

   // acc holds {partial product, remaining multiplier} or {remainder, quotient/dividend}.
   always_comb begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      if (op[2])
         acc_nxt = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
`endif
   end

   always_comb begin
      prod = neg ? -acc_nxt : acc_nxt;
      fin  = (op == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      qr = op[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
      if (op[2])
         fin = neg ? -qr : qr;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: default assignment first so no branch leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_i && !flush_i) state_nxt = special ? DONE : CALC;
         CALC: begin
            if (flush_i)   state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state != IDLE);
      done_o  = (state == DONE);
      stall_o = ((state == IDLE) && start_i && !flush_i) || (state == CALC);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt      <= '0;
         op       <= '0;
         rd_lat   <= '0;
         neg      <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         result_o <= '0;
         rd_o     <= '0;
      end else begin
         case (state)
            IDLE: if (start_i && !flush_i) begin
               op     <= funct3_i;
               rd_lat <= rd_i;
               neg    <= neg_in;
               cnt    <= '0;
               if (funct3_i[2]) begin
                  opnd <= mag2;
                  acc  <= {{XLEN{1'b0}}, mag1};
               end else begin
                  opnd <= mag1;
                  acc  <= {{XLEN{1'b0}}, mag2};
               end
               if (special) begin
                  result_o <= special_res;
                  rd_o     <= rd_i;
               end
            end
            CALC: if (!flush_i) begin
               acc <= acc_nxt;
               cnt <= cnt + 6'd1;
               if (last) begin
                  result_o <= fin;
                  rd_o     <= rd_lat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: multiply, divide (build-dependent), flush, reset.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, flush;
   logic [2:0]  funct3;
   logic [31:0] op1, op2;
   logic [4:0]  rd_in;
   logic        busy, stall, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int tests = 0;
   int fails = 0;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .flush_i  (flush),
      .funct3_i (funct3),
      .op1_i    (op1),
      .op2_i    (op2),
      .rd_i     (rd_in),
      .busy_o   (busy),
      .stall_o  (stall),
      .done_o   (done),
      .result_o (result),
      .rd_o     (rd_out)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one operation just after a rising edge and follows it to its done pulse.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_cycles);
      int edges  = 0;
      int stalls = 0;
      bit seen   = 0;
      funct3 = f3; op1 = a; op2 = b; rd_in = rd; start = 1'b1;
      #1;
      if (stall) stalls++;
      while (!seen && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         if (done)       seen = 1;
         else if (stall) stalls++;
      end
      check({tag, " done"},   32'(seen), 32'd1);
      check({tag, " edges"},  edges, exp_cycles);
      check({tag, " stalls"}, stalls, exp_cycles);
      check({tag, " result"}, result, exp_res);
      check({tag, " rd"},     {27'd0, rd_out}, {27'd0, rd});
      check({tag, " stall in DONE"}, 32'(stall), 32'd0);
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, " pulse ends"}, 32'(done), 32'd0);
      check({tag, " idle"},       32'(busy), 32'd0);
   endtask

   initial begin
      int dones;
      rst_n = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = '0; op1 = '0; op2 = '0; rd_in = '0;
      #2;
      check("reset busy",   32'(busy),  32'd0);
      check("reset done",   32'(done),  32'd0);
      check("reset stall",  32'(stall), 32'd0);
      check("reset result", result,     32'd0);
      check("reset rd",     {27'd0, rd_out}, 32'd0);
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("MUL 7*-3",   3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
      run_op("MULH min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 33);
      run_op("MULHSU min", 3'd2, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'hC000_0000, 33);
      run_op("MULHU min",  3'd3, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, 33);
      run_op("MUL 2*3",    3'd0, 32'd2,         32'd3,         5'd3, 32'd6,         33);

      // Flush ten iterations into CALC: no pulse, outputs keep the MUL 2*3 values.
      funct3 = 3'd0; op1 = 32'd5; op2 = 32'd6; rd_in = 5'd11; start = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
      end
      check("pre-flush busy", 32'(busy), 32'd1);
      flush = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy",   32'(busy), 32'd0);
      check("flush done",   32'(done), 32'd0);
      check("flush result", result,    32'd6);
      check("flush rd",     {27'd0, rd_out}, 32'd3);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("flush no pulse", dones, 0);

      run_op("MUL 3*4", 3'd0, 32'd3, 32'd4, 5'd12, 32'd12, 33);

      // Reset twenty iterations into CALC clears outputs without waiting for an edge.
      funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9; rd_in = 5'd13; start = 1'b1;
      for (int i = 0; i < 21; i++) begin
         @(posedge clk); #1;
      end
      check("pre-reset busy", 32'(busy), 32'd1);
      #1 start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid reset busy",   32'(busy),  32'd0);
      check("mid reset done",   32'(done),  32'd0);
      check("mid reset stall",  32'(stall), 32'd0);
      check("mid reset result", result,     32'd0);
      check("mid reset rd",     {27'd0, rd_out}, 32'd0);
      #2 rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 35; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("post reset busy",    32'(busy), 32'd0);
      check("post reset no pulse", dones,    0);

`ifdef MULDIV_DIV_EN
      run_op("DIV -7/2",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD, 33);
      run_op("REM -7/2",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF, 33);
      run_op("DIVU 100/7",  3'd5, 32'd100,       32'd7,         5'd16, 32'd14,        33);
      run_op("REMU 100/7",  3'd7, 32'd100,       32'd7,         5'd17, 32'd2,         33);
      run_op("DIV 5/0",     3'd4, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1);
      run_op("REM 5/0",     3'd6, 32'd5,         32'd0,         5'd19, 32'd5,         1);
      run_op("DIV ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);
      run_op("REM ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1);
`else
      run_op("DIVU 9/3 off", 3'd5, 32'd9,         32'd3, 5'd14, 32'd0, 1);
      run_op("DIV -7/2 off", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'd0, 1);
`endif

      run_op("MUL after div", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'd1, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, consuming the operand, `funct3` and `rd` fields held in the ID/EX pipeline register. When the decoder flags an M-extension instruction, the unit takes ownership of it. It holds the pipeline via `stall_o` while it computes. It then returns a 32-bit result and destination register for the EX/MEM register on a one-cycle `done_o` pulse.

## Interface
- `XLEN`, 32: operand/result width. Iteration count equals `XLEN`. Only 32 is supported.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  M-extension instruction present in ID/EX. Held high while stalled.
- `flush_i`  in  1  kill the in-flight operation (branch/jump flush).
- `funct3_i`  in  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `op1_i`  in  32  rs1 value (dividend / multiplicand).
- `op2_i`  in  32  rs2 value (divisor / multiplier).
- `rd_i`  in  5  destination register.
- `busy_o`  out  1  state is not IDLE.
- `stall_o`  out  1  combinational pipeline hold request.
- `done_o`  out  1  result valid, one-cycle pulse.
- `result_o`  out  32  result. Holds its value until the next completion.
- `rd_o`  out  5  destination register captured at start.

## Operation
- States:
  - IDLE: waiting for an operation.
  - CALC: iterating, with a 6-bit counter `cnt`.
  - DONE: result presented.
- IDLE:
  - If `start_i` and not `flush_i`, latch `funct3_i`, `rd_i`, operand magnitudes and sign flags.
  - Special cases go straight to DONE: divide-by-zero, and signed overflow (-2^31 / -1). All other operations go to CALC with `cnt` = 0.
- Multiply:
  - Shift-add on magnitudes into a 64-bit accumulator, one multiplier bit per cycle.
  - Signedness by opcode: MULH treats both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU and MUL treat both as unsigned.
  - The 64-bit product is negated when the effective signs differ.
  - MUL returns bits [31:0]. MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring, one quotient bit per cycle over 32-bit remainder/quotient registers, on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- Special results:
  - Divide by zero: DIV/DIVU return 32'hFFFF_FFFF; REM/REMU return the dividend.
  - DIV overflow returns 32'h8000_0000; REM overflow returns 0.
- CALC: each edge performs one iteration and increments `cnt`. On the edge where `cnt` = 31, sign correction is applied, `result_o`/`rd_o` are written, and the state moves to DONE.
- DONE: `done_o` = 1 and `start_i` is ignored. The next edge returns the state to IDLE unconditionally.
- `stall_o` = (IDLE & `start_i` & ~`flush_i`) | CALC. It is 0 in DONE, so ID/EX advances in the same cycle the result is consumed.
- `flush_i` takes priority in every state:
  - The next edge goes to IDLE.
  - No `done_o` pulse is issued, and `result_o`/`rd_o` are not updated.
  - `flush_i` in DONE does not suppress the pulse already showing.
- Back-to-back operations: a second M instruction is accepted in IDLE one cycle after DONE.

## Timing
- Reset (asynchronous, any state): state IDLE, `cnt` 0, `busy_o` 0, `done_o` 0, `result_o` 0, `rd_o` 0. `stall_o` is then purely `start_i`-driven.
- Normal operation: `start_i` is sampled at edge E0 and iterations run at E1..E32.
  - `done_o` is high for the cycle following E32, which is 32 cycles after acceptance.
  - `stall_o` is high from the cycle `start_i` rises through the cycle preceding DONE (33 cycles).
- Special-case divides: `done_o` is high in the cycle after E0, so `stall_o` lasts 1 cycle.
- Reset asserted mid-CALC: outputs clear immediately. After release the unit is in IDLE with no pulse.
- `busy_o` is registered-state derived. `stall_o` is combinational from `start_i`, `flush_i` and the state.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: divide/remainder (`funct3` 4-7) is implemented as above.
  - Undefined: the divider datapath and special-case logic are not synthesised. `funct3` 4-7 goes IDLE→DONE with `result_o` = 0 (1-cycle stall). Multiply behaviour is unchanged.

## Test plan
- MUL 7 × -3 (`op2` 32'hFFFF_FFFD) → `done_o` 32 cycles after start, `result_o` 32'hFFFF_FFEB, `rd_o` = `rd_i`.
- MULH/MULHSU/MULHU with `op1` = `op2` = 32'h8000_0000 → 32'h4000_0000 / 32'hC000_0000 / 32'h4000_0000.
- DIV -7/2 → 32'hFFFF_FFFD. REM -7/2 → 32'hFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2. Each completes in 32 cycles.
- DIV 5/0 → 32'hFFFF_FFFF and REM 5/0 → 5, each with a 1-cycle stall. DIV 32'h8000_0000 / -1 → 32'h8000_0000 with a 1-cycle stall.
- `flush_i` at cycle 10 of CALC → IDLE next edge, no `done_o`, `result_o` unchanged. A fresh MUL 3×4 immediately after → 12.
- `rst_ni` low at cycle 20 of CALC → all outputs 0 asynchronously. After release, `busy_o` = 0. With `MULDIV_DIV_EN` undefined, DIVU 9/3 → 0 after 1 cycle.
